// File: rtl/fetch_unit.sv
// Instruction fetch FSM: IDLE -> REQ (hold imem_req until ack) -> DONE (present instr, pulse PC write), with redirect capture and NPC generation.
// Latency: fetch_en to imem_req 1 cycle, imem_ack to instr_valid 1 cycle; a zero-wait, unstalled fetch takes 3 cycles.
// Backpressure: stall holds DONE with instr_valid asserted and suppresses PC_Write_Final. Optional macro FETCH_TIMEOUT_EN aborts a REQ after TIMEOUT_CYCLES.
module fetch_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        fetch_en,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] NPC,
  output logic        PC_Write_Final,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        expire;
  logic        pend_vld;
  logic [31:0] pend_tgt;
  logic [31:0] npc_raw;

  // A zero timeout would abort every fetch before memory could answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] to_cnt;
  logic          err_q;

  // Counter sits at zero outside REQ, so every entry into REQ starts a fresh count.
  assign expire = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Count REQ cycles spent waiting for the memory acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state != REQ) begin
      to_cnt <= '0;
    end else if (!expire) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  // One-cycle error pulse when a REQ expires; an ack in the same cycle cancels it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state == REQ) && !imem_ack && expire;
    end
  end

  assign fetch_err = err_q;
`else
  assign expire    = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // State register; reset is asynchronous so imem_req drops without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore/Mealy outputs; everything is quiet unless a state claims it.
  always_comb begin
    state_nxt      = state;
    imem_req       = 1'b0;
    imem_addr      = 32'h0;
    instr_valid    = 1'b0;
    PC_Write_Final = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_en) state_nxt = REQ;
      end
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = PC;
        if (imem_ack) begin
          state_nxt = DONE;
        end else if (expire) begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          PC_Write_Final = 1'b1;
          state_nxt      = fetch_en ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction register only captures an ack seen while actually requesting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= 32'h0;
    end else if ((state == REQ) && imem_ack) begin
      instr <= imem_rdata;
    end
  end

  // Pending redirect: retired by the PC write; otherwise the newest redirect wins.
  // A redirect during a stalled DONE is also kept so it is not lost to the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld <= 1'b0;
      pend_tgt <= 32'h0;
    end else if (PC_Write_Final) begin
      pend_vld <= 1'b0;
    end else if (redirect) begin
      pend_vld <= 1'b1;
      pend_tgt <= redirect_target;
    end
  end

  // Next-PC select: live redirect in DONE, then pending target, then sequential.
  always_comb begin
    npc_raw = PC + 32'd4;
    if ((state == DONE) && redirect) begin
      npc_raw = redirect_target;
    end else if (pend_vld) begin
      npc_raw = pend_tgt;
    end
  end

  // Instructions are word aligned, so the low address bits are always cleared.
  assign NPC = npc_raw & 32'hFFFF_FFFC;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        fetch_en;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] NPC;
  logic        PC_Write_Final;
  logic        fetch_err;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .PC(PC), .fetch_en(fetch_en), .stall(stall),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .NPC(NPC), .PC_Write_Final(PC_Write_Final), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fe, st, rd;
    logic [31:0] rt, pc;
    logic        ack;
    logic [31:0] rdata;
    logic        xreq;
    logic [31:0] xaddr;
    logic        xvld;
    logic [31:0] xinstr, xnpc;
    logic        xpcw;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic fe, st, rd, input logic [31:0] rt, pc,
                              input logic ack, input logic [31:0] rdata,
                              input logic xreq, input logic [31:0] xaddr, input logic xvld,
                              input logic [31:0] xinstr, xnpc, input logic xpcw);
    vec_t v;
    v.fe = fe; v.st = st; v.rd = rd; v.rt = rt; v.pc = pc; v.ack = ack; v.rdata = rdata;
    v.xreq = xreq; v.xaddr = xaddr; v.xvld = xvld; v.xinstr = xinstr; v.xnpc = xnpc;
    v.xpcw = xpcw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] act, exp;
    int  nreq;
    bit  got_err, pcw_seen, err_seen;

    // Reset state
    rst = 1'b0; PC = 32'h0; fetch_en = 0; stall = 0; redirect = 0;
    redirect_target = 32'h0; imem_ack = 0; imem_rdata = 32'h0;
    #2;
    chk("reset_outputs", {imem_req, instr_valid, PC_Write_Final, fetch_err, instr},
        {4'b0000, 32'h0});
    @(negedge clk); rst = 1'b1;

    //                 fe st rd rt            pc            ack rdata        req addr          vld instr         npc           pcw
    vecs[0]  = mk(1, 0, 0, 32'h0,        32'h0000_3000, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0000_3004, 0);
    vecs[1]  = mk(1, 0, 0, 32'h0,        32'h0000_3000, 1, 32'h2008_0005,1, 32'h0000_3000,0, 32'h0,        32'h0000_3004, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        32'h0000_3000, 0, 32'h0,        0, 32'h0,        1, 32'h2008_0005,32'h0000_3004, 1);
    vecs[3]  = mk(0, 0, 0, 32'h0,        32'h0000_3004, 1, 32'hDEAD_BEEF,0, 32'h0,        0, 32'h2008_0005,32'h0000_3008, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        32'h0000_3004, 0, 32'h0,        0, 32'h0,        0, 32'h2008_0005,32'h0000_3008, 0);
    vecs[5]  = mk(1, 0, 0, 32'h0,        32'h0000_3004, 0, 32'h0,        0, 32'h0,        0, 32'h2008_0005,32'h0000_3008, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,        32'h0000_3004, 0, 32'h0,        1, 32'h0000_3004,0, 32'h2008_0005,32'h0000_3008, 0);
    vecs[7]  = mk(1, 0, 0, 32'h0,        32'h0000_3004, 1, 32'h1111_1111,1, 32'h0000_3004,0, 32'h2008_0005,32'h0000_3008, 0);
    vecs[8]  = mk(1, 1, 0, 32'h0,        32'h0000_3004, 0, 32'h0,        0, 32'h0,        1, 32'h1111_1111,32'h0000_3008, 0);
    vecs[9]  = mk(1, 1, 0, 32'h0,        32'h0000_3004, 0, 32'h0,        0, 32'h0,        1, 32'h1111_1111,32'h0000_3008, 0);
    vecs[10] = mk(1, 1, 0, 32'h0,        32'h0000_3004, 0, 32'h0,        0, 32'h0,        1, 32'h1111_1111,32'h0000_3008, 0);
    vecs[11] = mk(1, 0, 0, 32'h0,        32'h0000_3004, 0, 32'h0,        0, 32'h0,        1, 32'h1111_1111,32'h0000_3008, 1);
    vecs[12] = mk(0, 0, 0, 32'h0,        32'h0000_3008, 0, 32'h0,        1, 32'h0000_3008,0, 32'h1111_1111,32'h0000_300C, 0);
    vecs[13] = mk(0, 0, 1, 32'h0000_3103,32'h0000_3008, 0, 32'h0,        1, 32'h0000_3008,0, 32'h1111_1111,32'h0000_300C, 0);
    vecs[14] = mk(0, 0, 0, 32'h0,        32'h0000_3008, 1, 32'h2222_2222,1, 32'h0000_3008,0, 32'h1111_1111,32'h0000_3100, 0);
    vecs[15] = mk(0, 0, 0, 32'h0,        32'h0000_3008, 0, 32'h0,        0, 32'h0,        1, 32'h2222_2222,32'h0000_3100, 1);
    vecs[16] = mk(0, 0, 0, 32'h0,        32'h0000_3100, 0, 32'h0,        0, 32'h0,        0, 32'h2222_2222,32'h0000_3104, 0);
    vecs[17] = mk(1, 0, 1, 32'h0000_4000,32'h0000_3100, 0, 32'h0,        0, 32'h0,        0, 32'h2222_2222,32'h0000_3104, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,        32'h0000_3100, 1, 32'h3333_3333,1, 32'h0000_3100,0, 32'h2222_2222,32'h0000_4000, 0);
    vecs[19] = mk(0, 0, 1, 32'h0000_5007,32'h0000_3100, 0, 32'h0,        0, 32'h0,        1, 32'h3333_3333,32'h0000_5004, 1);
    vecs[20] = mk(0, 0, 0, 32'h0,        32'h0000_5004, 0, 32'h0,        0, 32'h0,        0, 32'h3333_3333,32'h0000_5008, 0);
    vecs[21] = mk(1, 0, 0, 32'h0,        32'hFFFF_FFFC, 0, 32'h0,        0, 32'h0,        0, 32'h3333_3333,32'h0000_0000, 0);
    vecs[22] = mk(0, 0, 0, 32'h0,        32'hFFFF_FFFC, 1, 32'h4444_4444,1, 32'hFFFF_FFFC,0, 32'h3333_3333,32'h0000_0000, 0);
    vecs[23] = mk(0, 0, 0, 32'h0,        32'hFFFF_FFFC, 0, 32'h0,        0, 32'h0,        1, 32'h4444_4444,32'h0000_0000, 1);
    vecs[24] = mk(0, 0, 0, 32'h0,        32'h0000_0000, 0, 32'h0,        0, 32'h0,        0, 32'h4444_4444,32'h0000_0004, 0);

    // One row per clock: drive on the falling edge, compare just after.
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      fetch_en = vecs[i].fe; stall = vecs[i].st; redirect = vecs[i].rd;
      redirect_target = vecs[i].rt; PC = vecs[i].pc;
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
      #1;
      act = {27'h0, imem_req, imem_addr, instr_valid, instr, NPC, PC_Write_Final, fetch_err};
      exp = {27'h0, vecs[i].xreq, vecs[i].xaddr, vecs[i].xvld, vecs[i].xinstr,
             vecs[i].xnpc, vecs[i].xpcw, 1'b0};
      chk($sformatf("row%0d", i), act, exp);
    end

    // Reset in the middle of a REQ with a pending redirect
    @(negedge clk); fetch_en = 1; PC = 32'h0000_6000; imem_ack = 0; redirect = 0;
    @(negedge clk); redirect = 1; redirect_target = 32'h0000_7000;
    #1 chk("rstseq_in_req", {imem_req, imem_addr}, {1'b1, 32'h0000_6000});
    @(negedge clk); redirect = 0;
    #1 chk("rstseq_pending_npc", NPC, 32'h0000_7000);
    #2 rst = 1'b0;
    #1 chk("rstseq_async_drop", {imem_req, instr_valid, PC_Write_Final, instr},
           {3'b000, 32'h0});
    chk("rstseq_pending_cleared", NPC, 32'h0000_6004);
    @(negedge clk); rst = 1'b1; fetch_en = 0; imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    chk("late_ack_ignored", {imem_req, instr_valid, instr}, {2'b00, 32'h0});
    @(negedge clk); imem_ack = 0; fetch_en = 1;
    @(posedge clk); #1;
    chk("first_edge_after_reset", imem_req, 1'b1);
    @(negedge clk); fetch_en = 0; imem_ack = 1; imem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    chk("post_reset_fetch", {instr_valid, instr}, {1'b1, 32'h5555_5555});
    @(negedge clk); imem_ack = 0; stall = 0;
    #1 chk("post_reset_pcw", PC_Write_Final, 1'b1);

`ifdef FETCH_TIMEOUT_EN
    // No ack: expect exactly 16 REQ cycles, then one fetch_err cycle in IDLE
    @(negedge clk); fetch_en = 1;
    nreq = 0; got_err = 0; pcw_seen = 0;
    for (int i = 0; i < 100 && !got_err; i++) begin
      @(negedge clk); fetch_en = 0;
      #1;
      if (fetch_err) got_err = 1;
      else begin
        if (imem_req) nreq++;
        if (PC_Write_Final) pcw_seen = 1;
      end
    end
    chk("timeout_err_seen", got_err, 1'b1);
    chk("timeout_req_cycles", nreq, 16);
    chk("timeout_no_pcw", {pcw_seen, PC_Write_Final}, 2'b00);
    chk("timeout_idle", {imem_req, instr_valid, instr}, {2'b00, 32'h5555_5555});
    @(negedge clk); #1;
    chk("timeout_one_pulse", {fetch_err, imem_req}, 2'b00);

    // Ack arriving in the expiry cycle beats the timeout
    fetch_en = 1;
    err_seen = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); fetch_en = 0;
      imem_ack = (i == 15); imem_rdata = 32'h6666_6666;
      #1 if (fetch_err) err_seen = 1;
    end
    @(negedge clk); imem_ack = 0; stall = 0;
    #1 chk("expiry_ack_wins", {err_seen, fetch_err, instr_valid, instr},
           {3'b001, 32'h6666_6666});
`else
    // Without the timeout a REQ waits indefinitely and fetch_err never fires
    @(negedge clk); fetch_en = 1;
    nreq = 0; err_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); fetch_en = 0;
      #1;
      if (imem_req) nreq++;
      if (fetch_err) err_seen = 1;
    end
    chk("no_timeout_waits", nreq, 40);
    chk("no_timeout_err_tied", err_seen, 1'b0);
    imem_ack = 1; imem_rdata = 32'h7777_7777;
    @(negedge clk); imem_ack = 0;
    #1 chk("no_timeout_completes", {instr_valid, instr}, {1'b1, 32'h7777_7777});
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
